// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side FWFT word buffer sitting behind uart_rx.
// Captures each rx_ready strobe into a circular register FIFO, presents the
// head word on a valid/ready handshake and back-pressures uart_rx when full.
// Optional feature macro: UART_RX_FIFO_OVERFLOW_EN adds a sticky overflow
// flag, a saturating 8-bit drop counter and a synchronous clear input.
// depth must be a power of two and at least 2 so the pointers wrap naturally.
module uart_rx_fifo #(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 16
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     rx_ready,
    input  logic [width-1:0]         rx_data,
    output logic                     rx_can_receive_next_word,
    output logic                     out_valid,
    output logic [width-1:0]         out_data,
    input  logic                     out_ready,
    output logic [$clog2(depth):0]   level
`ifdef UART_RX_FIFO_OVERFLOW_EN
    ,
    output logic                     overflow,
    output logic [7:0]               drop_count,
    input  logic                     overflow_clear
`endif
);

    localparam int unsigned AW = $clog2(depth);
    localparam int unsigned LW = AW + 1;

    logic [width-1:0] r_mem [depth];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;

    // Handshake qualifiers; a full FIFO still accepts a word when it pops.
    always_comb begin
        w_full  = (r_level == LW'(depth));
        w_empty = (r_level == LW'(0));
        w_pop   = !w_empty && out_ready;
        w_push  = rx_ready && (!w_full || w_pop);
    end

    assign rx_can_receive_next_word = !w_full;
    assign out_valid                = !w_empty;
    assign out_data                 = r_mem[r_rd_ptr];
    assign level                    = r_level;

    // Storage array; contents are intentionally left unreset.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LW'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LW'(1);
            end
        end
    end

`ifdef UART_RX_FIFO_OVERFLOW_EN
    logic       w_drop;
    logic       r_overflow;
    logic [7:0] r_drop_count;

    assign w_drop     = rx_ready && w_full && !w_pop;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

    // Lost-word tracking; a drop coinciding with a clear counts as the first.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_overflow   <= 1'b0;
            r_drop_count <= 8'd0;
        end else if (overflow_clear) begin
            r_overflow   <= w_drop;
            r_drop_count <= w_drop ? 8'd1 : 8'd0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != 8'hFF) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo (depth 16, width 8): directed stimulus, a reference
// occupancy model feeding an expected-word queue, and a negedge monitor.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clock;
    logic       resetn;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_can_receive_next_word;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [4:0] level;
`ifdef UART_RX_FIFO_OVERFLOW_EN
    logic       overflow;
    logic [7:0] drop_count;
    logic       overflow_clear;
`endif

    uart_rx_fifo #(.width(8), .depth(DEPTH)) dut (
        .clock                    (clock),
        .resetn                   (resetn),
        .rx_ready                 (rx_ready),
        .rx_data                  (rx_data),
        .rx_can_receive_next_word (rx_can_receive_next_word),
        .out_valid                (out_valid),
        .out_data                 (out_data),
        .out_ready                (out_ready),
        .level                    (level)
`ifdef UART_RX_FIFO_OVERFLOW_EN
        ,
        .overflow                 (overflow),
        .drop_count               (drop_count),
        .overflow_clear           (overflow_clear)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int         checks    = 0;
    int         errors    = 0;
    int         m_level   = 0;
    int         m_drops   = 0;
    int         delivered = 0;
    int         last_out  = -1;
    bit         mon_en    = 0;
    logic [7:0] exp_q [$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Reference model: decides push/pop per edge and queues accepted words.
    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_level = 0;
            exp_q.delete();
        end else begin
            bit pop_m;
            bit push_m;
            pop_m  = (m_level != 0) && out_ready;
            push_m = rx_ready && ((m_level < DEPTH) || pop_m);
            if (rx_ready && !push_m) m_drops++;
            if (push_m) exp_q.push_back(rx_data);
            if (push_m && !pop_m) m_level++;
            else if (pop_m && !push_m) m_level--;
        end
    end

    // Monitor: compares flags and head word, retires words on handshake.
    always @(negedge clock) begin
        if (resetn && mon_en) begin
            chk("level", int'(level), m_level);
            chk("out_valid", int'(out_valid), int'(m_level != 0));
            chk("rx_can_receive", int'(rx_can_receive_next_word), int'(m_level != DEPTH));
            if (m_level != 0) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_nonempty", 0, 1);
                end else begin
                    chk("out_data", int'(out_data), int'(exp_q[0]));
                    if (out_ready) begin
                        last_out = int'(exp_q[0]);
                        void'(exp_q.pop_front());
                        delivered++;
                    end
                end
            end
        end
    end

    task automatic drive(input logic rx, input logic [7:0] d, input logic rdy);
        @(posedge clock);
        #1;
        rx_ready  = rx;
        rx_data   = d;
        out_ready = rdy;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (m_level != 0 && n < budget) begin
            drive(1'b0, 8'h00, 1'b1);
            n++;
        end
        drive(1'b0, 8'h00, 1'b0);
        chk("drain_timeout", int'(m_level == 0), 1);
    endtask

    initial begin
        int w;
        int n;
        int d0;
        resetn    = 1'b0;
        rx_ready  = 1'b0;
        rx_data   = 8'h00;
        out_ready = 1'b0;
`ifdef UART_RX_FIFO_OVERFLOW_EN
        overflow_clear = 1'b0;
`endif
        repeat (3) @(posedge clock);
        #1;
        chk("reset_level", int'(level), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_rx_can", int'(rx_can_receive_next_word), 1);
`ifdef UART_RX_FIFO_OVERFLOW_EN
        chk("reset_overflow", int'(overflow), 0);
        chk("reset_drop_count", int'(drop_count), 0);
`endif
        resetn = 1'b1;
        mon_en = 1;

        // Idle after reset.
        repeat (5) drive(1'b0, 8'h00, 1'b0);

        // Fill to full with no consumer, then drain in order.
        for (int i = 0; i < 16; i++) drive(1'b1, 8'(i), 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        @(negedge clock);
        chk("full_level", int'(level), 16);
        chk("full_rx_can", int'(rx_can_receive_next_word), 0);
        drain(40);
        chk("first_drain_count", delivered, 16);
        chk("first_drain_last", last_out, 8'h0F);

        // Refill, push during pop at full, then push with no pop (dropped).
        for (int i = 0; i < 16; i++) drive(1'b1, 8'(i), 1'b0);
        drive(1'b1, 8'hA5, 1'b1);
        drive(1'b1, 8'h5A, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        @(negedge clock);
        chk("full_after_simul_level", int'(level), 16);
        chk("model_drops", m_drops, 1);
`ifdef UART_RX_FIFO_OVERFLOW_EN
        chk("overflow_set", int'(overflow), 1);
        chk("drop_count_one", int'(drop_count), 1);
        @(posedge clock);
        #1;
        overflow_clear = 1'b1;
        @(posedge clock);
        #1;
        overflow_clear = 1'b0;
        @(negedge clock);
        chk("overflow_cleared", int'(overflow), 0);
        chk("drop_count_cleared", int'(drop_count), 0);
`endif
        d0 = delivered;
        drain(40);
        chk("second_drain_count", delivered - d0, 16);
        chk("second_drain_last", last_out, 8'hA5);

        // Streamed words 0..255 honouring backpressure, random consumer stalls.
        m_drops = 0;
        d0      = delivered;
        w       = 0;
        n       = 0;
        while ((w < 256 || m_level != 0) && n < 5000) begin
            @(posedge clock);
            #1;
            rx_ready  = (w < 256) && rx_can_receive_next_word && ($urandom_range(0, 2) == 0);
            rx_data   = 8'(w);
            out_ready = 1'($urandom_range(0, 1));
            if (rx_ready) w++;
            n++;
        end
        drive(1'b0, 8'h00, 1'b0);
        chk("stream_timeout", int'(n < 5000), 1);
        chk("stream_delivered", delivered - d0, 256);
        chk("stream_drops", m_drops, 0);
        chk("stream_last", last_out, 255);
`ifdef UART_RX_FIFO_OVERFLOW_EN
        chk("stream_overflow", int'(overflow), 0);
`endif

        // Reset while holding seven words.
        for (int i = 0; i < 7; i++) drive(1'b1, 8'(8'h30 + i), 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        @(negedge clock);
        chk("pre_reset_level", int'(level), 7);
        @(posedge clock);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_reset_level", int'(level), 0);
        chk("async_reset_out_valid", int'(out_valid), 0);
        chk("async_reset_rx_can", int'(rx_can_receive_next_word), 1);
        @(posedge clock);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        d0 = delivered;
        drive(1'b1, 8'h77, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        @(negedge clock);
        chk("post_reset_level", int'(level), 1);
        drain(10);
        chk("post_reset_delivered", delivered - d0, 1);
        chk("post_reset_word", last_out, 8'h77);
        chk("scoreboard_empty", exp_q.size(), 0);

        repeat (2) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
